counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 8 +
 rtl/scan_dff.sv | 20 ++
 rtl/counter.sv | 37 +++
 tb/tb_counter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the scannable counter.
package counter_pkg;

  localparam int unsigned COUNT_WIDTH = 8;

  typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage : counter_pkg

// File: rtl/scan_dff.sv
// One scannable flop: synchronous active-high reset, scan data wins over functional data when se=1.
module scan_dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic si,
  input  logic se,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= 1'b0;
    else if (se)
      q <= si;
    else
      q <= d;
  end

endmodule : scan_dff

// File: rtl/counter.sv
// Free-running WIDTH-bit counter whose register doubles as a serial scan chain (bit 0 in, MSB out).
module counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] scan_chain;

  assign cnt_inc    = cnt + WIDTH'(1);
  // Serial input of each bit is its lower neighbour; bit 0 takes scan_in.
  assign scan_chain = {cnt[WIDTH-2:0], scan_in};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    scan_dff u_scan_dff (
      .clk (clk),
      .rst (rst),
      .d   (cnt_inc[i]),
      .si  (scan_chain[i]),
      .se  (scan_en),
      .q   (cnt[i])
    );
  end

  assign result   = cnt;
  assign scan_out = cnt[WIDTH-1];

endmodule : counter

// File: tb/tb_counter.sv
// Scoreboard bench for counter: a reference model queues expected values per edge, compared after each edge.
module tb_counter;
  import counter_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   scan_en;
  logic   scan_drv;
  logic   loop_en;
  logic   scan_in;
  logic   scan_out;
  count_t result;

  typedef struct {
    count_t res;
    logic   so;
  } exp_t;

  exp_t   sb[$];
  count_t model;
  int     checks = 0;
  int     passes = 0;

  assign scan_in = loop_en ? scan_out : scan_drv;

  counter #(.WIDTH(8)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp)
      passes++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drive one edge worth of stimulus, predict the outcome, then compare after the edge.
  task automatic tick(input logic r, input logic se, input logic si);
    exp_t e;
    logic si_eff;
    rst      = r;
    scan_en  = se;
    scan_drv = si;
    si_eff   = loop_en ? model[7] : si;
    if (r)
      model = '0;
    else if (se)
      model = {model[6:0], si_eff};
    else
      model = model + 8'd1;
    e.res = model;
    e.so  = model[7];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sb_result", 32'(result), 32'(e.res));
      check("sb_scan_out", 32'(scan_out), 32'(e.so));
    end
  endtask

  task automatic count_n(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    count_t pat;
    count_t rot;
    rst      = 1'b1;
    scan_en  = 1'b0;
    scan_drv = 1'b0;
    loop_en  = 1'b0;
    model    = '0;

    // Reset
    tick(1'b1, 1'b0, 1'b0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_scan_out", 32'(scan_out), 32'd0);

    // Count and wrap
    count_n(10);
    check("count_10", 32'(result), 32'd10);
    count_n(245);
    check("count_255", 32'(result), 32'd255);
    check("count_255_so", 32'(scan_out), 32'd1);
    count_n(1);
    check("wrap_0", 32'(result), 32'd0);

    // Reset priority over scan at 0x7F
    count_n(127);
    check("pre_rst_7f", 32'(result), 32'h7F);
    tick(1'b1, 1'b1, 1'b1);
    check("rst_priority", 32'(result), 32'd0);
    check("rst_priority_so", 32'(scan_out), 32'd0);

    // Loopback rotation from 25
    count_n(25);
    check("pre_loop_25", 32'(result), 32'd25);
    loop_en = 1'b1;
    for (int unsigned k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b1, 1'b0);
      rot = 8'((32'd25 << k) | (32'd25 >> (8 - k)));
      check("loop_rot", 32'(result), 32'(rot));
    end
    check("loop_restored", 32'(result), 32'd25);
    loop_en = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    check("loop_resume", 32'(result), 32'd26);

    // External load of 0xA5, MSB first
    tick(1'b1, 1'b0, 1'b0);
    pat = 8'hA5;
    for (int k = 7; k >= 0; k--) tick(1'b0, 1'b1, pat[k]);
    check("load_a5", 32'(result), 32'hA5);
    check("load_a5_so", 32'(scan_out), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check("load_resume", 32'(result), 32'hA6);

    // Partial scan from 0x01
    tick(1'b1, 1'b0, 1'b0);
    count_n(1);
    for (int unsigned k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0);
    check("partial_08", 32'(result), 32'h08);
    tick(1'b0, 1'b0, 1'b0);
    check("partial_09", 32'(result), 32'h09);

    // Reset mid-scan discards shifted bits, then shifting continues
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    check("midscan_shifted", 32'(result), 32'h27);
    tick(1'b1, 1'b1, 1'b1);
    check("midscan_rst", 32'(result), 32'd0);
    tick(1'b0, 1'b1, 1'b1);
    check("midscan_after", 32'(result), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_counter
